// File: rtl/sampler_pkg.sv
// Shared types and constants for the triggered sampler.
package sampler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StPost,
    StDone
  } state_e;

  localparam logic TrigLevel = 1'b0;
  localparam logic TrigEdge  = 1'b1;

endpackage

// File: rtl/sampler_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sampler_ram #(
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrBits = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic                re_i,
  input  logic [AddrBits-1:0] raddr_i,
  output logic [Width-1:0]    rdata_o
);

  localparam int unsigned Depth = 2 ** AddrBits;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/triggered_sampler.sv
// Logic-analyser style capture: pre-trigger history, trigger search, then post-trigger fill.
module triggered_sampler
  import sampler_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TIME_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 sample_valid,
  input  logic                 arm,
  input  logic [TIME_BITS-1:0] pre_count,
  input  logic [WIDTH-1:0]     trig_mask,
  input  logic [WIDTH-1:0]     trig_value,
  input  logic                 trig_edge,
  input  logic                 force_trig,
  input  logic                 irq_clear,
  input  logic                 r_enable,
  input  logic [TIME_BITS-1:0] r_addr,
  output logic [WIDTH-1:0]     r_data,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic                 irq,
  output logic [TIME_BITS-1:0] trig_addr
);

  localparam int unsigned DEPTH = 2 ** TIME_BITS;
  localparam logic [TIME_BITS-1:0] LastAddr = TIME_BITS'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [TIME_BITS-1:0] w_addr_q, w_addr_d;
  logic [TIME_BITS-1:0] count_q, count_d;
  logic [TIME_BITS-1:0] remaining_q, remaining_d;
  logic [TIME_BITS-1:0] pre_q, pre_d;
  logic [TIME_BITS-1:0] trig_addr_q, trig_addr_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 edge_q, edge_d;
  logic                 prev_match_q, prev_match_d;
  logic                 triggered_q, triggered_d;
  logic                 done_q, done_d;
  logic                 irq_q, irq_d;

  logic                 we;
  logic                 match;
  logic                 trig_hit;
  logic [TIME_BITS-1:0] count_inc;
  logic [TIME_BITS-1:0] post_len;

  assign match     = ((sample_in ^ value_q) & mask_q) == '0;
  assign trig_hit  = force_trig || (edge_q == TrigEdge ? (match && !prev_match_q) : match);
  assign count_inc = count_q + 1'b1;
  assign post_len  = LastAddr - pre_q;

  always_comb begin
    state_d      = state_q;
    w_addr_d     = w_addr_q;
    count_d      = count_q;
    remaining_d  = remaining_q;
    pre_d        = pre_q;
    trig_addr_d  = trig_addr_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_d       = edge_q;
    prev_match_d = prev_match_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    irq_d        = irq_q;
    we           = 1'b0;

    if (arm) begin
      // pre_count is TIME_BITS wide, so it can never exceed DEPTH-1: the clamp is structural.
      pre_d        = pre_count;
      mask_d       = trig_mask;
      value_d      = trig_value;
      edge_d       = trig_edge;
      w_addr_d     = '0;
      count_d      = '0;
      remaining_d  = '0;
      prev_match_d = 1'b0;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
      irq_d        = 1'b0;
      state_d      = (pre_count == '0) ? StWait : StPre;
    end else begin
      if (irq_clear) begin
        irq_d = 1'b0;
      end
      unique case (state_q)
        StPre: begin
          if (sample_valid) begin
            we           = 1'b1;
            w_addr_d     = w_addr_q + 1'b1;
            prev_match_d = match;
            count_d      = count_inc;
            if (count_inc == pre_q) begin
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (sample_valid) begin
            we           = 1'b1;
            w_addr_d     = w_addr_q + 1'b1;
            prev_match_d = match;
            if (trig_hit) begin
              trig_addr_d = w_addr_q;
              triggered_d = 1'b1;
              remaining_d = post_len;
              if (post_len == '0) begin
                state_d = StDone;
                done_d  = 1'b1;
                irq_d   = 1'b1;
              end else begin
                state_d = StPost;
              end
            end
          end
        end
        StPost: begin
          if (sample_valid) begin
            we           = 1'b1;
            w_addr_d     = w_addr_q + 1'b1;
            prev_match_d = match;
            remaining_d  = remaining_q - 1'b1;
            if (remaining_q == TIME_BITS'(1)) begin
              state_d = StDone;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      w_addr_q     <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      pre_q        <= '0;
      trig_addr_q  <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= TrigLevel;
      prev_match_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_addr_q     <= w_addr_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      pre_q        <= pre_d;
      trig_addr_q  <= trig_addr_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_q       <= edge_d;
      prev_match_q <= prev_match_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
    end
  end

  sampler_ram #(
    .Width    (WIDTH),
    .AddrBits (TIME_BITS)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (we),
    .waddr_i (w_addr_q),
    .wdata_i (sample_in),
    .re_i    (r_enable),
    .raddr_i (r_addr),
    .rdata_o (r_data)
  );

  assign busy      = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
  assign triggered = triggered_q;
  assign done      = done_q;
  assign irq       = irq_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_triggered_sampler.sv
// Directed bench for triggered_sampler at WIDTH=8, TIME_BITS=4.
module tb_triggered_sampler;

  localparam int unsigned W  = 8;
  localparam int unsigned TB = 4;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  sample_in;
  logic          sample_valid;
  logic          arm;
  logic [TB-1:0] pre_count;
  logic [W-1:0]  trig_mask;
  logic [W-1:0]  trig_value;
  logic          trig_edge;
  logic          force_trig;
  logic          irq_clear;
  logic          r_enable;
  logic [TB-1:0] r_addr;
  logic [W-1:0]  r_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic          irq;
  logic [TB-1:0] trig_addr;

  int n_checks = 0;
  int n_fail   = 0;

  triggered_sampler #(
    .WIDTH     (W),
    .TIME_BITS (TB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .pre_count    (pre_count),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .trig_edge    (trig_edge),
    .force_trig   (force_trig),
    .irq_clear    (irq_clear),
    .r_enable     (r_enable),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .irq          (irq),
    .trig_addr    (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [TB-1:0] pre, input logic [W-1:0] mask,
                        input logic [W-1:0] value, input logic edge_mode);
    arm        = 1'b1;
    pre_count  = pre;
    trig_mask  = mask;
    trig_value = value;
    trig_edge  = edge_mode;
    step();
    arm = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic v, input logic f);
    sample_in    = d;
    sample_valid = v;
    force_trig   = f;
    step();
    sample_valid = 1'b0;
    force_trig   = 1'b0;
  endtask

  task automatic read_mem(input logic [TB-1:0] addr, output logic [W-1:0] data);
    r_enable = 1'b1;
    r_addr   = addr;
    step();
    r_enable = 1'b0;
    data     = r_data;
  endtask

  logic [W-1:0] rd;

  initial begin
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    pre_count    = '0;
    trig_mask    = '0;
    trig_value   = '0;
    trig_edge    = 1'b0;
    force_trig   = 1'b0;
    irq_clear    = 1'b0;
    r_enable     = 1'b0;
    r_addr       = '0;

    #7;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_triggered", 32'(triggered), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_trig_addr", 32'(trig_addr), 0);
    check_eq("rst_r_data", 32'(r_data), 0);
    #5;
    reset_n = 1'b1;
    step();

    // Level trigger: ramp from 0x18 so the surviving window starts at 0x1C.
    do_arm(4'd4, 8'hFF, 8'h20, 1'b0);
    check_eq("lvl_busy_after_arm", 32'(busy), 1);
    for (int i = 0; i < 8; i++) push(8'(8'h18 + i), 1'b1, 1'b0);
    check_eq("lvl_not_yet", 32'(triggered), 0);
    push(8'h20, 1'b1, 1'b0);
    check_eq("lvl_triggered", 32'(triggered), 1);
    check_eq("lvl_trig_addr", 32'(trig_addr), 8);
    for (int i = 1; i <= 10; i++) push(8'(8'h20 + i), 1'b1, 1'b0);
    check_eq("lvl_done_early", 32'(done), 0);
    push(8'h2B, 1'b1, 1'b0);
    check_eq("lvl_done", 32'(done), 1);
    check_eq("lvl_irq", 32'(irq), 1);
    check_eq("lvl_busy_done", 32'(busy), 0);
    push(8'hEE, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      read_mem(4'((4 + k) % 16), rd);
      check_eq($sformatf("lvl_mem_%0d", (4 + k) % 16), 32'(rd), 32'(8'h1C + k));
    end
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    check_eq("irq_clear_irq", 32'(irq), 0);
    check_eq("irq_clear_done", 32'(done), 1);

    // Edge mode: level held high through PRE must not fire; a fresh 00->20 does.
    do_arm(4'd2, 8'hFF, 8'h20, 1'b1);
    push(8'h20, 1'b1, 1'b1);
    check_eq("edge_force_in_pre", 32'(triggered), 0);
    push(8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(8'h20, 1'b1, 1'b0);
    check_eq("edge_held_high", 32'(triggered), 0);
    push(8'h00, 1'b1, 1'b0);
    check_eq("edge_low", 32'(triggered), 0);
    push(8'h20, 1'b1, 1'b0);
    check_eq("edge_rise", 32'(triggered), 1);
    check_eq("edge_trig_addr", 32'(trig_addr), 6);

    // pre_count = 0 with forced trigger on the first sample; irq_clear loses to the set.
    do_arm(4'd0, 8'hFF, 8'hAA, 1'b0);
    check_eq("force_busy", 32'(busy), 1);
    push(8'h00, 1'b1, 1'b1);
    check_eq("force_triggered", 32'(triggered), 1);
    check_eq("force_trig_addr", 32'(trig_addr), 0);
    for (int i = 1; i <= 14; i++) push(8'(i), 1'b1, 1'b0);
    check_eq("force_done_early", 32'(done), 0);
    irq_clear = 1'b1;
    push(8'h0F, 1'b1, 1'b0);
    irq_clear = 1'b0;
    check_eq("force_done", 32'(done), 1);
    check_eq("irq_set_beats_clear", 32'(irq), 1);

    // Valid gaps: only valid cycles advance the address and the post count.
    do_arm(4'd2, 8'hFF, 8'hAA, 1'b0);
    push(8'h01, 1'b1, 1'b0);
    push(8'h02, 1'b0, 1'b0);
    push(8'h03, 1'b1, 1'b0);
    push(8'h04, 1'b0, 1'b0);
    push(8'h05, 1'b0, 1'b1);
    check_eq("gap_invalid_force", 32'(triggered), 0);
    push(8'h06, 1'b1, 1'b1);
    check_eq("gap_triggered", 32'(triggered), 1);
    check_eq("gap_trig_addr", 32'(trig_addr), 2);
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h10 + i), 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b0);
    end
    check_eq("gap_done_early", 32'(done), 0);
    push(8'h30, 1'b1, 1'b0);
    check_eq("gap_done", 32'(done), 1);

    // Arm from DONE clears status; re-arm mid-POST restarts at address 0.
    do_arm(4'd0, 8'hFF, 8'hAA, 1'b0);
    check_eq("rearm_done_clr", 32'(done), 0);
    check_eq("rearm_irq_clr", 32'(irq), 0);
    check_eq("rearm_trig_clr", 32'(triggered), 0);
    push(8'h55, 1'b1, 1'b1);
    push(8'h56, 1'b1, 1'b0);
    push(8'h57, 1'b1, 1'b0);
    check_eq("post_running", 32'(busy), 1);
    do_arm(4'd1, 8'hFF, 8'hAA, 1'b0);
    check_eq("midpost_trig_clr", 32'(triggered), 0);
    check_eq("midpost_busy", 32'(busy), 1);
    push(8'h77, 1'b1, 1'b0);
    push(8'h78, 1'b1, 1'b1);
    check_eq("midpost_trig_addr", 32'(trig_addr), 1);
    read_mem(4'd0, rd);
    check_eq("midpost_mem0", 32'(rd), 32'h77);
    read_mem(4'd1, rd);
    check_eq("midpost_mem1", 32'(rd), 32'h78);

    // Asynchronous reset while waiting for a trigger.
    do_arm(4'd0, 8'hFF, 8'hAA, 1'b0);
    check_eq("wait_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_trig_addr", 32'(trig_addr), 0);
    check_eq("arst_r_data", 32'(r_data), 0);
    check_eq("arst_done", 32'(done), 0);
    check_eq("arst_irq", 32'(irq), 0);
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    step();
    push(8'hAA, 1'b1, 1'b1);
    check_eq("post_rst_no_trig", 32'(triggered), 0);
    check_eq("post_rst_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
